// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, 32-iteration multiply/divide
// with an upstream stall, and the registered CMP flag register.
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [4:0]       opcode,
  input  logic             cmp,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [3:0]       ex_rs1,
  input  logic [3:0]       ex_rs2,
  input  logic             mem_fwd_en,
  input  logic [3:0]       mem_fwd_dst,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic             wb_fwd_en,
  input  logic [3:0]       wb_fwd_dst,
  input  logic [WIDTH-1:0] wb_fwd_data,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] fwd_b,
  output logic             ex_valid,
  output logic             ex_stall,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [1:0]       md_op;

  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] md_res;
  logic             is_md;
  logic [WIDTH-1:0] flag_a;
  logic [WIDTH-1:0] flag_b;
  logic [WIDTH-1:0] fdiff;
  logic [3:0]       new_flags;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] trial;

  // MEM has priority over WB; register 0 is not special.
  always_comb begin
    fwd_a = rd1;
    if (mem_fwd_en && mem_fwd_dst == ex_rs1)
      fwd_a = mem_fwd_data;
    else if (wb_fwd_en && wb_fwd_dst == ex_rs1)
      fwd_a = wb_fwd_data;
    fwd_b = rd2;
    if (mem_fwd_en && mem_fwd_dst == ex_rs2)
      fwd_b = mem_fwd_data;
    else if (wb_fwd_en && wb_fwd_dst == ex_rs2)
      fwd_b = wb_fwd_data;
  end

  assign op_a  = fwd_a;
  assign op_b  = use_imm ? imm : fwd_b;
  assign is_md = (opcode == 5'h09) || (opcode == 5'h0A) || (opcode == 5'h0B);

  always_comb begin
    case (opcode)
      5'h00:   alu = '0;
      5'h01:   alu = op_a + op_b;
      5'h02:   alu = op_a - op_b;
      5'h03:   alu = op_a & op_b;
      5'h04:   alu = op_a | op_b;
      5'h05:   alu = op_a ^ op_b;
      5'h06:   alu = op_a << op_b[4:0];
      5'h07:   alu = op_a >> op_b[4:0];
      5'h08:   alu = WIDTH'($signed(op_a) >>> op_b[4:0]);
      default: alu = op_b;
    endcase
  end

  // Restoring divide step: a_reg shifts the dividend out and the quotient in, acc is the remainder.
  assign rem_shift = {1'b0, acc, a_reg[WIDTH-1]};
  assign trial     = rem_shift - {2'b00, b_reg};

  assign md_res = (md_op == 2'b10) ? a_reg : acc;

  // A multi-cycle op compares its captured operands, since the live forwarding paths have moved on.
  assign flag_a    = (state == DONE) ? cmp_a : op_a;
  assign flag_b    = (state == DONE) ? cmp_b : op_b;
  assign fdiff     = flag_a - flag_b;
  assign new_flags = {fdiff == '0, fdiff[WIDTH-1], flag_a >= flag_b,
                      (flag_a[WIDTH-1] ^ flag_b[WIDTH-1]) & (fdiff[WIDTH-1] ^ flag_a[WIDTH-1])};

  always_comb begin
    result   = '0;
    ex_valid = 1'b0;
    ex_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_md && !flush) begin
            ex_stall = 1'b1;
          end else begin
            ex_valid = !flush;
            result   = alu;
          end
        end
        BUSY: ex_stall = 1'b1;
        DONE: begin
          ex_valid = !flush;
          result   = md_res;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cmp_a <= '0;
      cmp_b <= '0;
      md_op <= '0;
      flags <= '0;
    end else begin
      if (cmp && ex_valid)
        flags <= new_flags;
      case (state)
        IDLE: begin
          if (is_md && !flush) begin
            a_reg <= op_a;
            b_reg <= op_b;
            cmp_a <= op_a;
            cmp_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
            md_op <= opcode[1:0];
            state <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (md_op == 2'b01) begin
              acc   <= acc + (b_reg[0] ? a_reg : '0);
              a_reg <= a_reg << 1;
              b_reg <= b_reg >> 1;
            end else begin
              acc   <= trial[WIDTH+1] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
              a_reg <= {a_reg[WIDTH-2:0], ~trial[WIDTH+1]};
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(ITER - 1))
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus pushes model results, a negedge monitor pops on ex_valid.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  opcode;
  logic        cmp;
  logic [31:0] rd1, rd2, imm;
  logic        use_imm;
  logic [3:0]  ex_rs1, ex_rs2;
  logic        mem_fwd_en, wb_fwd_en;
  logic [3:0]  mem_fwd_dst, wb_fwd_dst;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic [31:0] result, fwd_b;
  logic        ex_valid, ex_stall;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  exp_flags = 4'b0000;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .opcode(opcode), .cmp(cmp),
    .rd1(rd1), .rd2(rd2), .imm(imm), .use_imm(use_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_dst(mem_fwd_dst), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_dst(wb_fwd_dst), .wb_fwd_data(wb_fwd_data),
    .result(result), .fwd_b(fwd_b), .ex_valid(ex_valid), .ex_stall(ex_stall), .flags(flags)
  );

  function automatic logic [31:0] fwd_val(input logic [3:0] rs, input logic [31:0] rd);
    if (mem_fwd_en && mem_fwd_dst == rs) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_dst == rs) return wb_fwd_data;
    return rd;
  endfunction

  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      5'h00: r = 32'h0;
      5'h01: r = a + b;
      5'h02: r = a - b;
      5'h03: r = a & b;
      5'h04: r = a | b;
      5'h05: r = a ^ b;
      5'h06: r = a << b[4:0];
      5'h07: r = a >> b[4:0];
      5'h08: r = $signed(a) >>> b[4:0];
      5'h09: r = a * b;
      5'h0A: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h0B: r = (b == 0) ? a : a % b;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint sd;
    logic v;
    d  = a - b;
    sd = longint'($signed(a)) - longint'($signed(b));
    v  = (sd > longint'(32'sh7FFF_FFFF)) || (sd < -longint'(32'sh7FFF_FFFF) - 1);
    return {d == 32'h0, d[31], a >= b, v};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid EX output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && ex_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: got result %h with empty scoreboard at %0t", result, $time);
      end else begin
        checkOutput("result", result, exp_q.pop_front());
      end
    end
  end

  // Issue one instruction at posedge+1, follow it to completion, then leave a flush bubble.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a_rd, input logic [31:0] b_rd,
                               input logic [31:0] im, input logic ui, input logic c,
                               input logic [3:0] rs1, input logic [3:0] rs2);
    logic [31:0] a, fb, b;
    int  stalls;
    bit  fin, md;
    opcode = op; rd1 = a_rd; rd2 = b_rd; imm = im; use_imm = ui; cmp = c;
    ex_rs1 = rs1; ex_rs2 = rs2; flush = 1'b0;
    a  = fwd_val(rs1, a_rd);
    fb = fwd_val(rs2, b_rd);
    b  = ui ? im : fb;
    md = (op == 5'h09) || (op == 5'h0A) || (op == 5'h0B);
    exp_q.push_back(ref_op(op, a, b));
    stalls = 0;
    fin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) checkOutput("fwd_b", fwd_b, fb);
      if (!ex_stall) begin
        fin = 1'b1;
        break;
      end
      stalls++;
      @(posedge clk);
      #1;
      if (md) begin
        mem_fwd_data = $urandom; wb_fwd_data = $urandom;
        rd1 = $urandom; rd2 = $urandom;
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: op %h never completed", op);
    end
    checkOutput("stall_cycles", 32'(stalls), md ? 32'd33 : 32'd0);
    if (c) exp_flags = ref_flags(a, b);
    @(posedge clk);
    #1;
    flush = 1'b1;
    checkOutput("flags", {28'h0, flags}, {28'h0, exp_flags});
  endtask

  task automatic clearFwd();
    mem_fwd_en = 1'b0; wb_fwd_en = 1'b0;
    mem_fwd_dst = 4'd0; wb_fwd_dst = 4'd0;
    mem_fwd_data = 32'h0; wb_fwd_data = 32'h0;
  endtask

  initial begin
    logic [4:0] rop;
    rst = 1'b1; flush = 1'b0; opcode = 5'h09; cmp = 1'b1;
    rd1 = 32'h5; rd2 = 32'h3; imm = 32'h0; use_imm = 1'b0;
    ex_rs1 = 4'd1; ex_rs2 = 4'd2;
    clearFwd();
    #2;
    checkOutput("reset_stall", {31'h0, ex_stall}, 32'h0);
    checkOutput("reset_valid", {31'h0, ex_valid}, 32'h0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_flags", {28'h0, flags}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] forwarding priority");
    mem_fwd_en = 1'b1; mem_fwd_dst = 4'd3; mem_fwd_data = 32'h11;
    wb_fwd_en = 1'b1; wb_fwd_dst = 4'd3; wb_fwd_data = 32'h22;
    applyStimulus(5'h01, 32'h33, 32'h1, 32'h0, 1'b0, 1'b0, 4'd3, 4'd5);
    mem_fwd_en = 1'b0;
    applyStimulus(5'h01, 32'h33, 32'h1, 32'h0, 1'b0, 1'b0, 4'd3, 4'd5);
    wb_fwd_en = 1'b0;
    applyStimulus(5'h01, 32'h33, 32'h1, 32'h0, 1'b0, 1'b0, 4'd3, 4'd5);

    $display("[TB] compare flags");
    applyStimulus(5'h02, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 4'd1, 4'd2);
    checkOutput("cmp_flags_0101", {28'h0, flags}, 32'h5);
    applyStimulus(5'h02, 32'h4, 32'h4, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);

    $display("[TB] multiply / divide");
    applyStimulus(5'h09, 32'h1234_5678, 32'h10, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);
    applyStimulus(5'h0A, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);
    applyStimulus(5'h0B, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);
    applyStimulus(5'h0A, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);
    applyStimulus(5'h0B, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);
    clearFwd();

    $display("[TB] flush mid-divide");
    opcode = 5'h0A; rd1 = 32'd1000; rd2 = 32'd3; use_imm = 1'b0; cmp = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_valid", {31'h0, ex_valid}, 32'h0);
    checkOutput("flush_stall_held", {31'h0, ex_stall}, 32'h1);
    @(posedge clk);
    #1;
    applyStimulus(5'h01, 32'd2, 32'd3, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);

    $display("[TB] async reset mid-multiply");
    checkOutput("flags_before_reset", {28'h0, flags}, {28'h0, exp_flags});
    opcode = 5'h09; rd1 = 32'h7; rd2 = 32'h9; cmp = 1'b1; flush = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_stall", {31'h0, ex_stall}, 32'h0);
    checkOutput("midrst_valid", {31'h0, ex_valid}, 32'h0);
    checkOutput("midrst_flags", {28'h0, flags}, 32'h0);
    checkOutput("midrst_result", result, 32'h0);
    exp_flags = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(5'h09, 32'h0000_0123, 32'h0000_0456, 32'h0, 1'b0, 1'b0, 4'd1, 4'd2);

    $display("[TB] randomized instructions");
    for (int n = 0; n < 40; n++) begin
      rop = 5'($urandom_range(0, 13));
      if ($urandom_range(0, 9) == 0) rop = 5'h1F;
      mem_fwd_en = 1'($urandom_range(0, 1)); mem_fwd_dst = 4'($urandom_range(0, 3));
      wb_fwd_en = 1'($urandom_range(0, 1));  wb_fwd_dst = 4'($urandom_range(0, 3));
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      applyStimulus(rop, $urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. Consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Resolves operand forwarding from the MEM and WB stages.
- Performs single-cycle ALU operations and 32-iteration multiply/divide.
- Maintains the CMP flag register.
- Asserts ex_stall to freeze PC, IF/ID and ID/EX while a multi-cycle operation is in flight.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- ITER, 32, multiply/divide iterations; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the instruction in EX, including any multiply/divide in flight.
- opcode  in  5  operation from ID/EX.
- cmp  in  1  update flags from this instruction.
- rd1  in  32  register-file operand A from ID/EX.
- rd2  in  32  register-file operand B from ID/EX.
- imm  in  32  sign-extended immediate.
- use_imm  in  1  1 selects imm as operand B.
- ex_rs1  in  4  source register of operand A.
- ex_rs2  in  4  source register of operand B.
- mem_fwd_en  in  1  MEM stage writes a register.
- mem_fwd_dst  in  4  MEM stage destination register.
- mem_fwd_data  in  32  MEM stage result.
- wb_fwd_en  in  1  WB stage writes a register.
- wb_fwd_dst  in  4  WB stage destination register.
- wb_fwd_data  in  32  WB stage result.
- result  out  32  EX result to EX/MEM.
- fwd_b  out  32  forwarded rd2, used as store data.
- ex_valid  out  1  result is valid this cycle; 0 means EX/MEM loads a bubble.
- ex_stall  out  1  hold upstream stages.
- flags  out  4  {Z,N,C,V}, registered.

Behaviour:
- Forwarding, combinational, per operand:
  - If mem_fwd_en and mem_fwd_dst==rs, use mem_fwd_data.
  - Else if wb_fwd_en and wb_fwd_dst==rs, use wb_fwd_data.
  - Else use rd1/rd2. MEM has priority over WB.
  - Register 0 is forwarded like any other register.
  - Operand B = use_imm ? imm : forwarded rd2.
- Opcodes (anything not listed below: result = operand B):
  - 00 NOP: result 0, ex_valid 1.
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR.
  - 06 SLL, 07 SRL, 08 SRA: shift amount is B[4:0].
  - 09 MUL: low 32 bits of the product.
  - 0A DIVU: unsigned quotient.
  - 0B REMU: unsigned remainder.
- Single-cycle ops: result and ex_valid=1 are combinational in the same cycle; ex_stall=0. All arithmetic wraps modulo 2^32.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on opcode in {09,0A,0B} with flush=0: ex_stall=1 combinationally, ex_valid=0. At the clock edge, latch forwarded A/B into internal operand registers, clear the counter, go to BUSY. Operands are captured once because forwarding sources move during the stall.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) iteration per cycle. ex_stall=1, ex_valid=0. After iteration ITER-1, go to DONE.
  - DONE: result = latched product/quotient/remainder, ex_valid=1, ex_stall=0. Next edge returns to IDLE while ID/EX loads the next instruction.
  - Timing: a multiply/divide occupies EX for 34 cycles (1 IDLE + 32 BUSY + 1 DONE), with ex_stall high for exactly 33 cycles.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. No trap is raised.
- Flags:
  - Registered. They update only on a cycle where cmp=1, ex_valid=1 and flush=0.
  - Computed from A-B: Z = diff==0; N = diff[31]; C = A>=B unsigned (no borrow); V = signed overflow of the subtraction.
  - cmp together with a multiply/divide opcode updates flags in the DONE cycle only.
- flush:
  - In IDLE it forces ex_valid=0 and blocks the multiply/divide start.
  - In BUSY or DONE it returns the FSM to IDLE at the next edge; ex_valid=0 that cycle and ex_stall drops the following cycle.
  - flush has priority over cmp.
- Reset, including mid-operation:
  - FSM goes to IDLE.
  - Counter, operand registers and accumulator are cleared to 0.
  - flags = 0.
  - ex_stall = 0 and ex_valid = 0 while rst is high, regardless of opcode.
  - result = 0 while rst is high.

Test Plan:
- Forwarding priority: ex_rs1=3, mem_fwd (en, dst 3, data 0x11), wb_fwd (en, dst 3, data 0x22), rd1=0x33, rd2=1, opcode ADD -> result 0x12. Drop mem_fwd_en -> 0x23. Drop both -> 0x34.
- CMP flags: A=0x7FFFFFFF, B=0xFFFFFFFF, cmp=1, SUB -> result 0x80000000, flags {Z,N,C,V}=0101 after the edge. Repeat with cmp=0 -> flags unchanged.
- MUL timing: A=0x12345678, B=0x10, opcode 09 -> ex_stall high for exactly 33 cycles; DONE cycle has result 0x23456780 and ex_valid=1. Forwarding inputs changed during BUSY do not alter the result.
- DIVU/REMU: 100/7 -> quotient 14, then REMU gives 2. Divide by zero with A=0xDEADBEEF, B=0 -> DIVU 0xFFFFFFFF, REMU 0xDEADBEEF.
- Flush mid-DIVU at BUSY iteration 10 -> ex_valid=0, ex_stall low one cycle later. A following ADD 2+3 then completes with result 5 in a single cycle.
- Async reset asserted mid-MUL, between clock edges -> ex_stall and ex_valid drop immediately and flags=0. After release, the FSM is in IDLE and a fresh MUL takes the full 34 cycles.
